gf2m_digit_serial_mult: RTL and testbench
=========================================

// Module: gf2m_digit_serial_mult
// PURPOSE
//  Parametrised digit-serial GF(2^m) multiplier with in-line polynomial reduction: c = a*b mod f(x).
//  Successor to the fixed-width combinational Karatsuba product trees, which give the unreduced product only.
//  Trades latency for area: it folds DIGIT bits of b per clock, MSB first.
//  Sits between the ECC point-arithmetic controller and the field register file.
//  Uses a valid/ready handshake on both sides.
// PARAMETERS
//  WIDTH  163     field degree m; operands and result are WIDTH bits
//  DIGIT  4       bits of b consumed per clock, 1..WIDTH
//  POLY   'hC9    f(x) - x^WIDTH, WIDTH bits wide (default x^7+x^6+x^3+1, the NIST B/K-163 modulus)
//  Derived: N = ceil(WIDTH/DIGIT) compute cycles; K = deg(POLY).
//  Elaboration error unless DIGIT+K <= WIDTH, so that one fold reduces completely.
// PORTS
//  clk        in   1      clock, rising edge
//  rst_n      in   1      asynchronous active-low reset
//  in_valid   in   1      operands valid
//  in_ready   out  1      block can accept operands
//  in_a       in   WIDTH  operand a, degree < WIDTH
//  in_b       in   WIDTH  operand b, degree < WIDTH
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_c      out  WIDTH  a*b mod f, degree < WIDTH
//  busy       out  1      high in RUN or DONE
// BEHAVIOUR
//  Reset (async assert, sync release): state=IDLE; in_ready=0; out_valid=0; out_c=0; acc=0; cnt=0.
//   in_ready is registered and rises on the first clk edge after rst_n deasserts.
//  FSM IDLE -> RUN -> DONE -> IDLE. All outputs are registered. in_ready=1 only in IDLE.
//  IDLE: at the edge E0 where in_valid&in_ready:
//   - latch a and b; b is zero-extended at the top to N*DIGIT bits;
//   - acc=0, cnt=N-1, in_ready=0, go to RUN.
//  RUN, edges E1..EN: per edge, with d = b digit[cnt] (MSB-first):
//   - acc <= red(acc*x^DIGIT) ^ red(a*d);
//   - red() folds bits >= WIDTH: bit WIDTH+j, for j < DIGIT, XORs (POLY<<j) into the low part;
//   - a*d is the carry-less product of a and the DIGIT-bit digit d.
//   At EN (cnt==0): out_c=final acc, out_valid=1, go to DONE.
//   Latency: out_valid visible N cycles after E0 (41 for the defaults).
//   Zero-padded top digits contribute 0.
//  DONE: out_c and out_valid hold stable while out_ready=0.
//   On the edge with out_ready=1: out_valid=0, in_ready=1, go to IDLE.
//   Throughput: one result per N+2 cycles when out_ready is held high.
//  in_valid is ignored outside IDLE; in_a/in_b may change freely after E0.
//  out_ready is ignored outside DONE.
//  Reset mid-RUN or mid-DONE aborts the operation; no partial result is emitted.
//  Corner results: a=0 or b=0 -> 0; b=1 -> a; a=1 -> b.
//  No operand-dependent timing: always exactly N RUN cycles (constant time, side-channel requirement).
// TESTING
//  T1 defaults, a=1, b=1 -> out_c=1; out_valid rises exactly 41 cycles after the accept edge.
//  T2 a=x^162, b=x -> out_c=163'hC9 (reduction of x^163).
//   a=b=x^162 -> x^324 mod f, checked against the bench reference model.
//  T3 10k random a,b, out_ready randomly toggled:
//   - every out_c matches the software shift-and-add mod-f model;
//   - out_c stable while out_valid&!out_ready; in_ready=0 throughout.
//  T4 assert rst_n low at RUN cycle 20:
//   - out_valid=0 and in_ready=0 immediately (asynchronous);
//   - the next op after release (a=3, b=5 -> 15) is correct.
//  T5 in_valid held high back-to-back with out_ready=1:
//   - exactly one accept per N+2 cycles;
//   - no operand dropped or duplicated.
//  T6 re-elaborate with WIDTH=41, DIGIT=1 / DIGIT=8 / DIGIT=41-K:
//   - the N=11 case (DIGIT=4) exercises 3 padding bits;
//   - results match the model; an illegal DIGIT+K>WIDTH elaboration fails.

Source files
------------

// File: rtl/gf2m_digit_serial_mult.sv
// ----------------------------------------------------------------------------
// gf2m_digit_serial_mult
//
// Digit-serial GF(2^m) multiplier with in-line reduction: out_c = a*b mod f(x),
// where f(x) = x^WIDTH + POLY. Each RUN clock folds one DIGIT-bit digit of b
// (MSB first) into the accumulator:
//     acc <= red(acc * x^DIGIT) ^ red(a * d)
// Both terms share one reduction stage because red() is linear over GF(2).
// Every operation takes exactly N = ceil(WIDTH/DIGIT) RUN cycles regardless of
// operand values, so timing leaks nothing about the operands.
//
// Parameters
//   WIDTH  field degree m (operand/result width)
//   DIGIT  bits of b consumed per clock, 1..WIDTH
//   POLY   f(x) - x^WIDTH; DIGIT + deg(POLY) <= WIDTH is required so that one
//          fold leaves a fully reduced value
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands valid (sampled only in IDLE)
//   in_ready   registered; high only in IDLE
//   in_a       operand a, WIDTH bits
//   in_b       operand b, WIDTH bits
//   out_valid  registered; result valid, held in DONE until out_ready
//   out_ready  consumer accepts result (sampled only in DONE)
//   out_c      registered result a*b mod f
//   busy       high in RUN or DONE
// ----------------------------------------------------------------------------
module gf2m_digit_serial_mult #(
  parameter int               WIDTH = 163,
  parameter int               DIGIT = 4,
  parameter logic [WIDTH-1:0] POLY  = 'hC9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_c,
  output logic             busy
);

  // Number of RUN cycles and padded width of b.
  localparam int N  = (WIDTH + DIGIT - 1) / DIGIT;
  localparam int BW = N * DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  // Degree of the reduction polynomial tail.
  function automatic int poly_deg(input logic [WIDTH-1:0] p);
    int d;
    d = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (p[i]) d = i;
    end
    return d;
  endfunction

  localparam int K = poly_deg(POLY);

  // Reject parameter sets the datapath cannot handle.
  if (DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_digit
    $error("gf2m_digit_serial_mult: DIGIT must be in 1..WIDTH");
  end
  if (DIGIT + K > WIDTH) begin : g_bad_poly
    $error("gf2m_digit_serial_mult: DIGIT + deg(POLY) must not exceed WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_c_q, out_c_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  // b is zero-extended at the top to whole digits and shifted left each RUN
  // cycle, so the current digit always sits in the top DIGIT bits.
  logic [BW-1:0]    b_q, b_d;

  // --------------------------------------------------------------------------
  // Datapath: one digit step
  // --------------------------------------------------------------------------
  logic [DIGIT-1:0]       digit;
  logic [WIDTH+DIGIT-1:0] ext_a;
  logic [WIDTH+DIGIT-1:0] pp [DIGIT];
  logic [WIDTH+DIGIT-1:0] pp_sum;
  logic [WIDTH+DIGIT-1:0] wide;
  logic [WIDTH-1:0]       rt [DIGIT];
  logic [WIDTH-1:0]       rt_sum;
  logic [WIDTH-1:0]       acc_step;

  assign digit = b_q[BW-1 -: DIGIT];
  assign ext_a = {{DIGIT{1'b0}}, a_q};

  // Carry-less partial products a * x^gi for each set digit bit.
  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_pp
    assign pp[gi] = digit[gi] ? (ext_a << gi) : '0;
  end

  always_comb begin
    pp_sum = '0;
    for (int i = 0; i < DIGIT; i++) begin
      pp_sum = pp_sum ^ pp[i];
    end
  end

  // Unreduced acc*x^DIGIT ^ a*d; it has at most DIGIT bits at or above WIDTH.
  assign wide = {acc_q, {DIGIT{1'b0}}} ^ pp_sum;

  // x^(WIDTH+gi) == POLY * x^gi (mod f). Since deg(POLY)+gi < WIDTH, each
  // folded term lands entirely in the low part and no second pass is needed.
  for (genvar gi = 0; gi < DIGIT; gi++) begin : g_fold
    assign rt[gi] = wide[WIDTH+gi] ? (POLY << gi) : '0;
  end

  always_comb begin
    rt_sum = '0;
    for (int i = 0; i < DIGIT; i++) begin
      rt_sum = rt_sum ^ rt[i];
    end
  end

  assign acc_step = wide[WIDTH-1:0] ^ rt_sum;

  // --------------------------------------------------------------------------
  // Control: next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    out_c_d     = out_c_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;

    case (state_q)
      S_IDLE: begin
        // in_ready rises on the first edge after reset release, so no
        // operands can be taken on that edge.
        in_ready_d = 1'b1;
        if (in_valid && in_ready_q) begin
          a_d        = in_a;
          b_d        = BW'(in_b);
          acc_d      = '0;
          cnt_d      = CW'(N - 1);
          in_ready_d = 1'b0;
          state_d    = S_RUN;
        end
      end

      S_RUN: begin
        acc_d = acc_step;
        b_d   = b_q << DIGIT;
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) begin
          cnt_d       = '0;
          out_c_d     = acc_step;
          out_valid_d = 1'b1;
          state_d     = S_DONE;
        end
      end

      S_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d     = S_IDLE;
        in_ready_d  = 1'b0;
        out_valid_d = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_c_q     <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_c_q     <= out_c_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_c     = out_c_q;
  assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_gf2m_digit_serial_mult.sv
// ----------------------------------------------------------------------------
// tb_gf2m_digit_serial_mult
//
// Two instances: the default GF(2^163) multiplier (DIGIT=4, N=41) and a
// GF(2^41) one (DIGIT=4, N=11, three zero-padded bits of b). A select signal
// routes the shared stimulus to one of them and muxes its outputs for
// checking. Expected results come from a bit-serial shift-and-add mod f
// reference model.
// ----------------------------------------------------------------------------
module tb_gf2m_digit_serial_mult;

  localparam int W1 = 163;
  localparam int N1 = 41;
  localparam int W2 = 41;
  localparam int N2 = 11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         sel = 1'b0;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [162:0] in_a = '0;
  logic [162:0] in_b = '0;

  logic         m_in_valid, m_out_ready, m_in_ready, m_out_valid, m_busy;
  logic [162:0] m_out_c;
  logic         s_in_valid, s_out_ready, s_in_ready, s_out_valid, s_busy;
  logic [40:0]  s_in_a, s_in_b, s_out_c;

  logic         obs_in_ready, obs_out_valid, obs_busy;
  logic [162:0] obs_out_c;

  int n_assert = 0;
  int n_fail   = 0;

  assign m_in_valid  = in_valid & ~sel;
  assign m_out_ready = out_ready & ~sel;
  assign s_in_valid  = in_valid & sel;
  assign s_out_ready = out_ready & sel;
  assign s_in_a      = in_a[40:0];
  assign s_in_b      = in_b[40:0];

  assign obs_in_ready  = sel ? s_in_ready  : m_in_ready;
  assign obs_out_valid = sel ? s_out_valid : m_out_valid;
  assign obs_busy      = sel ? s_busy      : m_busy;
  assign obs_out_c     = sel ? {122'b0, s_out_c} : m_out_c;

  always #5 clk = ~clk;

  gf2m_digit_serial_mult #(
    .WIDTH(163),
    .DIGIT(4),
    .POLY (163'hC9)
  ) u_dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (m_in_valid),
    .in_ready (m_in_ready),
    .in_a     (in_a),
    .in_b     (in_b),
    .out_valid(m_out_valid),
    .out_ready(m_out_ready),
    .out_c    (m_out_c),
    .busy     (m_busy)
  );

  gf2m_digit_serial_mult #(
    .WIDTH(41),
    .DIGIT(4),
    .POLY (41'h9)
  ) u_dut_small (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (s_in_valid),
    .in_ready (s_in_ready),
    .in_a     (s_in_a),
    .in_b     (s_in_b),
    .out_valid(s_out_valid),
    .out_ready(s_out_ready),
    .out_c    (s_out_c),
    .busy     (s_busy)
  );

  // Shift-and-add multiplication mod x^w + poly, one bit of b at a time.
  function automatic logic [162:0] ref_mul(input logic [162:0] a, input logic [162:0] b,
                                           input int w, input logic [162:0] poly);
    logic [163:0] r;
    r = '0;
    for (int i = w - 1; i >= 0; i--) begin
      r = r << 1;
      if (r[w]) begin
        r[w] = 1'b0;
        r = r ^ {1'b0, poly};
      end
      if (b[i]) r = r ^ {1'b0, a};
    end
    return r[162:0];
  endfunction

  function automatic int cur_w();
    return sel ? W2 : W1;
  endfunction

  function automatic int cur_n();
    return sel ? N2 : N1;
  endfunction

  function automatic logic [162:0] cur_poly();
    return sel ? 163'h9 : 163'hC9;
  endfunction

  function automatic logic [162:0] cur_mask();
    logic [162:0] m;
    m = '1;
    if (sel) m = {122'b0, {41{1'b1}}};
    return m;
  endfunction

  // Random operand with a bias towards corner values.
  function automatic logic [162:0] rnd_op();
    logic [191:0] t;
    int           mode;
    mode = int'($urandom_range(0, 7));
    t = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (mode == 0) return '0;
    if (mode == 1) return 163'd1;
    if (mode == 2) return (163'd1 << $urandom_range(0, 162)) & cur_mask();
    return t[162:0] & cur_mask();
  endfunction

  task automatic check(input string tag, input logic [162:0] obs, input logic [162:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Wait (bounded) for in_ready, present operands and pass the accept edge.
  task automatic accept_op(input logic [162:0] a, input logic [162:0] b, input string tag);
    int waitc;
    waitc = 0;
    while (!obs_in_ready && waitc < 100) begin
      @(posedge clk); #1;
      waitc++;
    end
    check({tag, "_ready_wait"}, 163'(obs_in_ready), 163'd1);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // One full transaction with latency, result, hold and release checks.
  task automatic do_op(input logic [162:0] a, input logic [162:0] b, input bit rnd,
                       input string tag, output logic [162:0] c);
    logic [162:0] exp;
    logic [162:0] held;
    int           lat;
    int           hold;
    exp = ref_mul(a & cur_mask(), b & cur_mask(), cur_w(), cur_poly());
    accept_op(a, b, tag);
    if (rnd) begin
      in_valid = 1'($urandom);
      in_a = rnd_op();
      in_b = rnd_op();
    end
    check({tag, "_in_ready_run"}, 163'(obs_in_ready), 163'd0);
    check({tag, "_busy_run"}, 163'(obs_busy), 163'd1);
    lat = 0;
    while (!obs_out_valid && lat < 200) begin
      out_ready = rnd ? 1'($urandom) : 1'b0;
      @(posedge clk); #1;
      lat++;
      if (rnd) begin
        in_valid = 1'($urandom);
        in_a = rnd_op();
        in_b = rnd_op();
      end
    end
    check({tag, "_latency"}, 163'(lat), 163'(cur_n()));
    check({tag, "_result"}, obs_out_c, exp);
    c = obs_out_c;
    held = obs_out_c;
    hold = rnd ? int'($urandom_range(0, 3)) : 0;
    for (int i = 0; i < hold; i++) begin
      out_ready = 1'b0;
      @(posedge clk); #1;
      check({tag, "_hold_valid"}, 163'(obs_out_valid), 163'd1);
      check({tag, "_hold_c"}, obs_out_c, held);
      check({tag, "_hold_in_ready"}, 163'(obs_in_ready), 163'd0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    in_valid = 1'b0;
    check({tag, "_rel_valid"}, 163'(obs_out_valid), 163'd0);
    check({tag, "_rel_in_ready"}, 163'(obs_in_ready), 163'd1);
    check({tag, "_rel_busy"}, 163'(obs_busy), 163'd0);
    $display("txn %s: a=%h b=%h c=%h lat=%0d", tag, a & cur_mask(), b & cur_mask(), c, lat);
  endtask

  // in_valid held high with out_ready=1: accepts must be spaced N+2 apart and
  // results must come back in order, once each.
  task automatic back_to_back(input int nops, input string tag);
    logic [162:0] exp_q[$];
    logic [162:0] exp;
    int           accepts;
    int           results;
    int           last_acc;
    int           cyc;
    bit           accept_now;
    accepts  = 0;
    results  = 0;
    last_acc = -1;
    out_ready = 1'b1;
    in_a = rnd_op();
    in_b = rnd_op();
    in_valid = 1'b1;
    for (cyc = 1; cyc <= nops * (cur_n() + 2) + cur_n() + 10; cyc++) begin
      accept_now = obs_in_ready && in_valid;
      @(posedge clk); #1;
      if (accept_now) begin
        if (last_acc >= 0) check({tag, "_spacing"}, 163'(cyc - last_acc), 163'(cur_n() + 2));
        last_acc = cyc;
        exp_q.push_back(ref_mul(in_a & cur_mask(), in_b & cur_mask(), cur_w(), cur_poly()));
        accepts++;
        if (accepts < nops) begin
          in_a = rnd_op();
          in_b = rnd_op();
        end else begin
          in_valid = 1'b0;
        end
      end
      if (obs_out_valid) begin
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
        check({tag, "_result"}, obs_out_c, exp);
        $display("txn %s #%0d: c=%h", tag, results, obs_out_c);
        results++;
      end
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    check({tag, "_accepts"}, 163'(accepts), 163'(nops));
    check({tag, "_results"}, 163'(results), 163'(nops));
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [162:0] a;
    logic [162:0] b;
    logic [162:0] c;
    int           waitc;

    // ---------------- reset state ----------------
    #1 rst_n = 1'b0;
    #1;
    check("rst_in_ready", 163'(m_in_ready), 163'd0);
    check("rst_out_valid", 163'(m_out_valid), 163'd0);
    check("rst_out_c", m_out_c, 163'd0);
    check("rst_busy", 163'(m_busy), 163'd0);
    check("rst_small_in_ready", 163'(s_in_ready), 163'd0);
    check("rst_small_out_c", {122'b0, s_out_c}, 163'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_low", 163'(m_in_ready), 163'd0);
    @(posedge clk); #1;
    check("rel_in_ready_rise", 163'(m_in_ready), 163'd1);

    // ---------------- directed, default field ----------------
    sel = 1'b0;
    do_op(163'd1, 163'd1, 1'b0, "t1_one", c);
    check("t1_const", c, 163'd1);
    do_op(163'd1 << 162, 163'd2, 1'b0, "t2_x163", c);
    check("t2_const", c, 163'hC9);
    do_op(163'd1 << 162, 163'd1 << 162, 1'b0, "t2_x324", c);
    a = rnd_op() | 163'd4;
    b = rnd_op() | 163'd8;
    do_op(163'd0, b, 1'b0, "corner_a0", c);
    check("corner_a0_const", c, 163'd0);
    do_op(a, 163'd0, 1'b0, "corner_b0", c);
    check("corner_b0_const", c, 163'd0);
    do_op(a, 163'd1, 1'b0, "corner_b1", c);
    check("corner_b1_const", c, a);
    do_op(163'd1, b, 1'b0, "corner_a1", c);
    check("corner_a1_const", c, b);

    // ---------------- reset during DONE ----------------
    accept_op(rnd_op(), rnd_op(), "t4_done");
    waitc = 0;
    while (!m_out_valid && waitc < 200) begin
      @(posedge clk); #1;
      waitc++;
    end
    check("t4_done_reached", 163'(m_out_valid), 163'd1);
    rst_n = 1'b0;
    #1;
    check("t4_done_out_valid", 163'(m_out_valid), 163'd0);
    check("t4_done_out_c", m_out_c, 163'd0);
    check("t4_done_busy", 163'(m_busy), 163'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // ---------------- reset during RUN cycle 20 ----------------
    accept_op((163'd1 << 100) | 163'd7, 163'hDEADBEEF, "t4_run");
    repeat (19) @(posedge clk);
    #1;
    check("t4_run_busy", 163'(m_busy), 163'd1);
    rst_n = 1'b0;
    #1;
    check("t4_run_out_valid", 163'(m_out_valid), 163'd0);
    check("t4_run_in_ready", 163'(m_in_ready), 163'd0);
    check("t4_run_busy_clr", 163'(m_busy), 163'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("t4_rel_in_ready_low", 163'(m_in_ready), 163'd0);
    @(posedge clk); #1;
    check("t4_rel_in_ready_rise", 163'(m_in_ready), 163'd1);
    do_op(163'd3, 163'd5, 1'b0, "t4_after", c);
    check("t4_after_const", c, 163'd15);

    // ---------------- random, default field ----------------
    for (int i = 0; i < 250; i++) begin
      do_op(rnd_op(), rnd_op(), 1'b1, "t3_rand", c);
    end

    // ---------------- back-to-back, default field ----------------
    back_to_back(5, "t5_b2b");

    // ---------------- GF(2^41), DIGIT=4 (padded b) ----------------
    sel = 1'b1;
    @(posedge clk); #1;
    do_op(163'd1, 163'd1, 1'b0, "t6_one", c);
    check("t6_one_const", c, 163'd1);
    do_op(163'd1 << 40, 163'd2, 1'b0, "t6_x41", c);
    check("t6_x41_const", c, 163'h9);
    do_op(163'd1 << 40, 163'd1 << 40, 1'b0, "t6_x80", c);
    do_op({122'b0, {41{1'b1}}}, {122'b0, {41{1'b1}}}, 1'b0, "t6_ones", c);
    for (int i = 0; i < 150; i++) begin
      do_op(rnd_op(), rnd_op(), 1'b1, "t6_rand", c);
    end
    back_to_back(5, "t6_b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
